// File: rtl/floo_mesh_link_buffer_if.sv
// -----------------------------------------------------------------------------
// floo_mesh_link_buffer_if
// Valid/ready flit channel used on either side of the mesh link buffer.
//   valid : flit valid, driven by the sender
//   ready : receiver can take the flit this cycle
//   data  : flit payload incl. header (FlitWidth bits)
// Modports: master = sender side, slave = receiver side.
// -----------------------------------------------------------------------------
interface floo_mesh_link_buffer_if #(
  parameter int unsigned FlitWidth = 64
);
  logic                 valid;
  logic                 ready;
  logic [FlitWidth-1:0] data;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/floo_mesh_link_buffer.sv
// -----------------------------------------------------------------------------
// floo_mesh_link_buffer
// Elastic buffer on one inter-tile mesh link channel. All handshake outputs
// come straight from flops, so no combinational valid/ready path crosses the
// link, while Depth>=2 still sustains one flit per cycle.
// Ports:
//   clk_i       : link clock, rising edge
//   rst_i       : asynchronous reset, active-high
//   clr_i       : synchronous clear of contents and counters
//   i_up        : upstream channel (slave: valid/data in, ready out)
//   o_dn        : downstream channel (master: valid/data out, ready in)
//   fill_o      : number of stored flits
//   flit_cnt_o  : flits delivered downstream, wraps
//   stall_cnt_o : cycles with valid out but no ready, saturates
// -----------------------------------------------------------------------------
module floo_mesh_link_buffer #(
  parameter int unsigned FlitWidth = 64,
  parameter int unsigned Depth     = 2,
  parameter int unsigned CntWidth  = 16,
  localparam int unsigned FillW    = $clog2(Depth + 1),
  localparam int unsigned PtrW     = $clog2(Depth)
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         clr_i,
  floo_mesh_link_buffer_if.slave       i_up,
  floo_mesh_link_buffer_if.master      o_dn,
  output logic [FillW-1:0]             fill_o,
  output logic [CntWidth-1:0]          flit_cnt_o,
  output logic [CntWidth-1:0]          stall_cnt_o
);

  logic [FlitWidth-1:0] r_mem [Depth];
  logic [PtrW-1:0]      r_wr_ptr;
  logic [PtrW-1:0]      r_rd_ptr;
  logic [FillW-1:0]     r_fill;
  logic                 r_valid;
  logic                 r_ready;
  logic [CntWidth-1:0]  r_flit_cnt;
  logic [CntWidth-1:0]  r_stall_cnt;

  logic                 w_push;
  logic                 w_pop;
  logic                 w_stall;
  logic [FillW-1:0]     w_fill_nxt;
  logic [PtrW-1:0]      w_wr_ptr_nxt;
  logic [PtrW-1:0]      w_rd_ptr_nxt;

  // Handshakes qualified only by registered flags.
  assign w_push  = i_up.valid & r_ready;
  assign w_pop   = r_valid & o_dn.ready;
  assign w_stall = r_valid & ~o_dn.ready;

  // Occupancy and pointer successors; wrap by explicit compare so any Depth works.
  always_comb begin
    w_fill_nxt   = r_fill;
    w_wr_ptr_nxt = r_wr_ptr;
    w_rd_ptr_nxt = r_rd_ptr;
    case ({w_push, w_pop})
      2'b10:   w_fill_nxt = r_fill + FillW'(1);
      2'b01:   w_fill_nxt = r_fill - FillW'(1);
      default: w_fill_nxt = r_fill;
    endcase
    if (w_push) begin
      w_wr_ptr_nxt = (r_wr_ptr == PtrW'(Depth - 1)) ? PtrW'(0) : r_wr_ptr + PtrW'(1);
    end else begin
      w_wr_ptr_nxt = r_wr_ptr;
    end
    if (w_pop) begin
      w_rd_ptr_nxt = (r_rd_ptr == PtrW'(Depth - 1)) ? PtrW'(0) : r_rd_ptr + PtrW'(1);
    end else begin
      w_rd_ptr_nxt = r_rd_ptr;
    end
  end

  // Control state, handshake flags and counters; clear wins over push/pop.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_wr_ptr    <= PtrW'(0);
      r_rd_ptr    <= PtrW'(0);
      r_fill      <= FillW'(0);
      r_valid     <= 1'b0;
      r_ready     <= 1'b1;
      r_flit_cnt  <= CntWidth'(0);
      r_stall_cnt <= CntWidth'(0);
    end else if (clr_i) begin
      r_wr_ptr    <= PtrW'(0);
      r_rd_ptr    <= PtrW'(0);
      r_fill      <= FillW'(0);
      r_valid     <= 1'b0;
      r_ready     <= 1'b1;
      r_flit_cnt  <= CntWidth'(0);
      r_stall_cnt <= CntWidth'(0);
    end else begin
      r_wr_ptr    <= w_wr_ptr_nxt;
      r_rd_ptr    <= w_rd_ptr_nxt;
      r_fill      <= w_fill_nxt;
      // Flags are precomputed from next occupancy so outputs are pure flops.
      r_valid     <= (w_fill_nxt != FillW'(0));
      r_ready     <= (w_fill_nxt != FillW'(Depth));
      r_flit_cnt  <= w_pop ? (r_flit_cnt + CntWidth'(1)) : r_flit_cnt;
      if (w_stall && (r_stall_cnt != {CntWidth{1'b1}})) begin
        r_stall_cnt <= r_stall_cnt + CntWidth'(1);
      end else begin
        r_stall_cnt <= r_stall_cnt;
      end
    end
  end

  // Flit storage; contents are don't-care after reset, so no reset term.
  always_ff @(posedge clk_i) begin
    if (w_push && !clr_i) begin
      r_mem[r_wr_ptr] <= i_up.data;
    end
  end

  assign i_up.ready  = r_ready;
  assign o_dn.valid  = r_valid;
  assign o_dn.data   = r_mem[r_rd_ptr];
  assign fill_o      = r_fill;
  assign flit_cnt_o  = r_flit_cnt;
  assign stall_cnt_o = r_stall_cnt;

  floo_mesh_link_buffer_chk #(
    .FlitWidth (FlitWidth),
    .Depth     (Depth),
    .FillW     (FillW)
  ) u_chk (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .valid_i (i_up.valid),
    .ready_i (r_ready),
    .data_i  (i_up.data),
    .fill_i  (r_fill)
  );

endmodule

// -----------------------------------------------------------------------------
// floo_mesh_link_buffer_chk
// Property checker for the link buffer: legal depth, occupancy bound and the
// upstream hold-until-accepted rule. Contains no functional logic.
// -----------------------------------------------------------------------------
module floo_mesh_link_buffer_chk #(
  parameter int unsigned FlitWidth = 64,
  parameter int unsigned Depth     = 2,
  parameter int unsigned FillW     = 2
) (
  input logic                 clk_i,
  input logic                 rst_i,
  input logic                 valid_i,
  input logic                 ready_i,
  input logic [FlitWidth-1:0] data_i,
  input logic [FillW-1:0]     fill_i
);

  if (Depth < 2) begin : g_bad_depth
    $error("floo_mesh_link_buffer: Depth must be at least 2");
  end

  a_fill_bound: assert property (@(posedge clk_i) disable iff (rst_i)
    fill_i <= FillW'(Depth));

  // A flit offered while the buffer is full must stay offered, unchanged.
  a_up_hold: assert property (@(posedge clk_i) disable iff (rst_i)
    (valid_i && !ready_i) |=> (valid_i && $stable(data_i)));

endmodule

// File: tb/tb_floo_mesh_link_buffer.sv
// -----------------------------------------------------------------------------
// tb_floo_mesh_link_buffer
// Directed and random stimulus against a queue-based reference model of the
// link buffer (Depth=3, CntWidth=8 so counter boundaries are reachable).
// -----------------------------------------------------------------------------
module tb_floo_mesh_link_buffer;
  localparam int unsigned FW = 16;
  localparam int unsigned D  = 3;
  localparam int unsigned CW = 8;

  logic clk = 1'b0;
  logic rst;
  logic clr;
  logic [1:0]    fill;
  logic [CW-1:0] flit_cnt;
  logic [CW-1:0] stall_cnt;

  always #5 clk = ~clk;

  floo_mesh_link_buffer_if #(.FlitWidth(FW)) up_if ();
  floo_mesh_link_buffer_if #(.FlitWidth(FW)) dn_if ();

  floo_mesh_link_buffer #(.FlitWidth(FW), .Depth(D), .CntWidth(CW)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .clr_i       (clr),
    .i_up        (up_if),
    .o_dn        (dn_if),
    .fill_o      (fill),
    .flit_cnt_o  (flit_cnt),
    .stall_cnt_o (stall_cnt)
  );

  // Reference model: queue of stored flits plus plain integer counters.
  logic [FW-1:0] q[$];
  int m_flit;
  int m_stall;
  bit last_push;
  int n_cmp  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_flit  = 0;
    m_stall = 0;
  endtask

  task automatic check_state();
    chk("ready_o", {31'd0, up_if.ready}, {31'd0, (q.size() != D)});
    chk("valid_o", {31'd0, dn_if.valid}, {31'd0, (q.size() != 0)});
    chk("fill_o", {30'd0, fill}, q.size());
    chk("flit_cnt_o", {24'd0, flit_cnt}, m_flit);
    chk("stall_cnt_o", {24'd0, stall_cnt}, m_stall);
    if (q.size() != 0) chk("data_o", {16'd0, dn_if.data}, {16'd0, q[0]});
  endtask

  // One clock: compare, then advance the model with the inputs just applied.
  task automatic tick();
    bit push, pop, stall;
    logic [FW-1:0] din;
    check_state();
    push  = up_if.valid && (q.size() != D);
    pop   = (q.size() != 0) && dn_if.ready;
    stall = (q.size() != 0) && !dn_if.ready;
    din   = up_if.data;
    @(posedge clk);
    if (clr) begin
      model_reset();
      last_push = 1'b0;
    end else begin
      if (pop) begin
        void'(q.pop_front());
        m_flit = (m_flit + 1) % (1 << CW);
      end
      if (push) q.push_back(din);
      if (stall && m_stall < (1 << CW) - 1) m_stall++;
      last_push = push;
    end
    #2;
  endtask

  initial begin
    int d;
    int n_sent;
    int cyc;
    rst = 1'b1;
    clr = 1'b0;
    up_if.valid = 1'b0;
    up_if.data  = '0;
    dn_if.ready = 1'b0;
    last_push = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #2;
    check_state();
    rst = 1'b0;

    // Streaming: 100 flits back to back, in order, no stalls.
    dn_if.ready = 1'b1;
    for (int i = 0; i < 100; i++) begin
      up_if.valid = 1'b1;
      up_if.data  = FW'(i);
      tick();
      if (i == 0) chk("first_valid", {31'd0, dn_if.valid}, 32'd1);
    end
    up_if.valid = 1'b0;
    repeat (2) tick();
    chk("stream_flits", {24'd0, flit_cnt}, 32'd100);
    chk("stream_stall", {24'd0, stall_cnt}, 32'd0);

    // Back-pressure: 5 offered, only Depth accepted while downstream stalls.
    dn_if.ready = 1'b0;
    d = 0;
    for (int k = 0; k < 6; k++) begin
      up_if.valid = 1'b1;
      up_if.data  = FW'(200 + d);
      tick();
      if (last_push) d++;
    end
    chk("bp_fill", {30'd0, fill}, 32'd3);
    chk("bp_ready", {31'd0, up_if.ready}, 32'd0);
    chk("bp_stall", {24'd0, stall_cnt}, 32'd5);
    dn_if.ready = 1'b1;
    for (int k = 0; k < 20 && d < 5; k++) begin
      up_if.data = FW'(200 + d);
      tick();
      if (last_push) d++;
    end
    up_if.valid = 1'b0;
    repeat (4) tick();
    chk("bp_flits", {24'd0, flit_cnt}, 32'd105);

    // Full with a pop in the same cycle: no pass-through of ready.
    dn_if.ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      up_if.valid = 1'b1;
      up_if.data  = FW'(300 + k);
      tick();
    end
    dn_if.ready = 1'b1;
    up_if.data  = FW'(303);
    chk("fullpop_ready", {31'd0, up_if.ready}, 32'd0);
    tick();
    chk("fullpop_fill", {30'd0, fill}, 32'd2);
    chk("fullpop_ready_next", {31'd0, up_if.ready}, 32'd1);
    tick();
    up_if.valid = 1'b0;
    repeat (4) tick();

    // Asynchronous reset with two flits stored.
    dn_if.ready = 1'b0;
    for (int k = 0; k < 2; k++) begin
      up_if.valid = 1'b1;
      up_if.data  = FW'(400 + k);
      tick();
    end
    up_if.valid = 1'b0;
    #1;
    rst = 1'b1;
    #1;
    chk("rst_valid", {31'd0, dn_if.valid}, 32'd0);
    chk("rst_ready", {31'd0, up_if.ready}, 32'd1);
    chk("rst_fill", {30'd0, fill}, 32'd0);
    chk("rst_flit", {24'd0, flit_cnt}, 32'd0);
    chk("rst_stall", {24'd0, stall_cnt}, 32'd0);
    model_reset();
    @(posedge clk);
    #2;
    rst = 1'b0;
    tick();

    // Stall counter saturation.
    up_if.valid = 1'b1;
    up_if.data  = 16'h0055;
    tick();
    up_if.valid = 1'b0;
    repeat (300) tick();
    chk("stall_sat", {24'd0, stall_cnt}, 32'h0000_00FF);
    dn_if.ready = 1'b1;
    repeat (2) tick();

    // Flit counter wrap: 2^CW + 1 flits leave it at 1.
    clr = 1'b1;
    tick();
    clr = 1'b0;
    for (int i = 0; i < 257; i++) begin
      up_if.valid = 1'b1;
      up_if.data  = FW'(i * 7);
      tick();
    end
    up_if.valid = 1'b0;
    repeat (2) tick();
    chk("flit_wrap", {24'd0, flit_cnt}, 32'd1);

    // Synchronous clear with two flits stored, then a fresh flit A.
    dn_if.ready = 1'b0;
    for (int k = 0; k < 2; k++) begin
      up_if.valid = 1'b1;
      up_if.data  = FW'(500 + k);
      tick();
    end
    up_if.valid = 1'b0;
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("clr_fill", {30'd0, fill}, 32'd0);
    chk("clr_valid", {31'd0, dn_if.valid}, 32'd0);
    chk("clr_flit", {24'd0, flit_cnt}, 32'd0);
    chk("clr_stall", {24'd0, stall_cnt}, 32'd0);
    dn_if.ready = 1'b1;
    up_if.valid = 1'b1;
    up_if.data  = 16'hA5A5;
    tick();
    up_if.valid = 1'b0;
    chk("clr_a_valid", {31'd0, dn_if.valid}, 32'd1);
    chk("clr_a_data", {16'd0, dn_if.data}, 32'h0000_A5A5);
    tick();

    // Random valid/ready traffic; upstream holds each flit until accepted.
    n_sent = 0;
    cyc    = 0;
    while (n_sent < 3000 && cyc < 20000) begin
      if (!up_if.valid && $urandom_range(0, 3) != 0) begin
        up_if.valid = 1'b1;
        up_if.data  = FW'($urandom);
      end
      dn_if.ready = ($urandom_range(0, 3) != 0);
      tick();
      if (last_push) begin
        n_sent++;
        up_if.valid = 1'b0;
      end
      cyc++;
    end
    chk("rand_budget", {31'd0, (n_sent >= 3000)}, 32'd1);
    up_if.valid = 1'b0;
    dn_if.ready = 1'b1;
    repeat (5) tick();
    chk("rand_drained", {30'd0, fill}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
